// File: rtl/block_mem_arbiter.sv
// Round-robin arbiter sequencing 256-bit line transfers from the I-side refill
// port and the D-side read/write-back port onto one variable-latency memory port.
// Stalls the pipeline (FREEZE) while any transfer is pending.
module block_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              iBlkRead,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] block_read_fIM,
  output logic              i_done,
  input  logic              dBlkRead,
  input  logic              dBlkWrite,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] block_write_2DM,
  output logic [LINE_W-1:0] block_read_fDM,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              FREEZE,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;    // 0 = I-side, 1 = D-side
  logic               last_d_q, last_d_d;  // last completed grant went to D
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LINE_W-1:0]  wdata_q, wdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [LINE_W-1:0]  iline_q, iline_d;
  logic [LINE_W-1:0]  dline_q, dline_d;
  logic               pend_i, pend_d, grant_d;

  // State and datapath registers; reset aborts any transfer in flight.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_d_q <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      iline_q  <= '0;
      dline_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_d_q <= last_d_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      iline_q  <= iline_d;
      dline_q  <= dline_d;
    end
  end

  // Grant selection, timeout counting and read-data capture.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d_d = last_d_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    iline_d  = iline_q;
    dline_d  = dline_q;
    pend_i   = iBlkRead;
    pend_d   = dBlkRead | dBlkWrite;
    grant_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pend_i || pend_d) begin
          // On a tie the side that did not win last time gets the port.
          grant_d = pend_d && (!pend_i || !last_d_q);
          owner_d = grant_d;
          // A D-side write-back goes ahead of a simultaneous D-side read.
          we_d    = grant_d & dBlkWrite;
          addr_d  = grant_d ? d_addr : i_addr;
          wdata_d = (grant_d & dBlkWrite) ? block_write_2DM : '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_ack) begin
          if (!we_q) begin
            if (owner_q) dline_d = mem_rdata;
            else         iline_d = mem_rdata;
          end
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // Requests are ignored here so a requester dropping now is not re-granted.
        last_d_d = owner_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req        = (state_q == BUSY);
  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign i_done         = (state_q == DONE) & ~owner_q;
  assign d_done         = (state_q == DONE) &  owner_q;
  assign block_read_fIM = iline_q;
  assign block_read_fDM = dline_q;
  assign err            = err_q;
  assign FREEZE         = (state_q != IDLE) | iBlkRead | dBlkRead | dBlkWrite;

endmodule
